rr_resource_sched: RTL
======================

Name: rr_resource_sched

Overview:
- Round-robin scheduler that shares one DUT-level resource among NUM_REQ requesters.
- Each requester raises a request. The scheduler grants exactly one requester at a time, launches the resource with a start pulse plus the winner's ID, and holds the grant until the resource reports done or a watchdog timeout fires.
- Sits between the requester agents and the shared datapath inside the top-level dut.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ), width of the winner ID.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before the grant is forcibly revoked; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk, input, 1, sole clock; all state changes on the rising edge.
- rst, input, 1, reset: asynchronous, active-low (0 = reset).
- req_i, input, NUM_REQ, level request per requester.
- gnt_o, output, NUM_REQ, one-hot-or-zero grant, registered.
- res_start_o, output, 1, one-cycle pulse launching the resource, registered.
- res_sel_o, output, ID_W, ID of the current/last winner, registered.
- res_done_i, input, 1, resource completion pulse; sampled only in BUSY.
- busy_o, output, 1, high while a grant is outstanding (state BUSY).
- timeout_o, output, 1, one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0, asserted asynchronously, released synchronously to clk):
  - state=IDLE; gnt_o=0, res_start_o=0, res_sel_o=0, busy_o=0, timeout_o=0; watchdog counter=0.
  - RR pointer last_id=NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE, BUSY.
- Arbitration (combinational, used in IDLE and on the done edge in BUSY):
  - Search order is last_id+1, last_id+2, … modulo NUM_REQ, wrapping.
  - The first set bit of req_i wins.
  - The previous winner has lowest priority next round.
- IDLE, any req_i set at edge t:
  - At t+1: state=BUSY; gnt_o=onehot(winner); res_sel_o=winner; res_start_o=1 for exactly that cycle; busy_o=1; last_id=winner; counter=0.
  - Latency from request to grant is one cycle.
- IDLE, req_i=0: outputs stay idle; res_done_i is ignored.
- BUSY:
  - gnt_o and res_sel_o hold regardless of req_i; a winner dropping req does not revoke the grant.
  - The counter increments each cycle, saturating.
  - res_done_i outside BUSY is ignored; res_done_i in the same cycle as res_start_o is also ignored, since the counter must be ≥1 to count done.
- BUSY, res_done_i=1 at edge t (back-to-back permitted):
  - If arbitration (using the updated pointer = current winner) finds a requester: at t+1 a new grant and a new res_start_o pulse are issued; state stays BUSY; counter=0. The same requester may win again only if no other requester is asserting.
  - Otherwise: at t+1 gnt_o=0, busy_o=0, state=IDLE. res_sel_o keeps its last value.
- Watchdog (TIMEOUT_CYCLES≠0):
  - If the counter reaches TIMEOUT_CYCLES with no done: next edge gives gnt_o=0, busy_o=0, timeout_o=1 for one cycle, state=IDLE. Re-arbitration starts from IDLE on the following cycle.
  - Done and expiry in the same cycle: done wins and timeout_o stays 0.
- Invariants:
  - gnt_o is never multi-hot.
  - res_start_o is high only on the first cycle of each grant.
  - busy_o equals (gnt_o!=0).
- Reset mid-BUSY: all outputs drop asynchronously, with no timeout_o pulse. After release the pointer again favours requester 0.
- Width rule: pointer arithmetic is modulo NUM_REQ, correct for non-power-of-two NUM_REQ (e.g. 3).

Test Plan:
- Reset then req_i=4'b0110 → 1 cycle later gnt_o=0010, res_sel_o=1, res_start_o=1 for 1 cycle, busy_o=1.
- req_i=4'b1111 held, res_done_i pulsed 3 cycles after each start → grants in order 0001,0010,0100,1000,0001, each with one res_start_o pulse and no idle gap.
- Winner 2 drops req_i mid-grant → gnt_o stays 0100 until res_done_i; then, if req_i=0, gnt_o=0 next cycle and busy_o=0.
- TIMEOUT_CYCLES=5, grant with no done → gnt_o drops and timeout_o=1 for exactly 1 cycle, 6 cycles after the start. Repeat with done asserted on the expiry cycle → timeout_o stays 0.
- Assert rst=0 asynchronously mid-BUSY (between edges) → gnt_o=0 and busy_o=0 immediately. After release with req_i=4'b1001 → requester 0 granted first.
- NUM_REQ=3, req_i=3'b111 → grant sequence 0,1,2,0 (wrap check); res_done_i pulses in IDLE produce no outputs.

Source files
------------

// File: rtl/rr_resource_sched.sv
// -----------------------------------------------------------------------------
// rr_resource_sched
//   Round-robin scheduler that shares one resource among NUM_REQ requesters.
//   A winner is picked from req_i starting just after the last winner, the
//   resource is launched with a one-cycle start pulse plus the winner's ID,
//   and the grant is held until res_done_i or until the watchdog expires.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   req_i        : level request per requester
//   gnt_o        : one-hot-or-zero grant (registered)
//   res_start_o  : one-cycle launch pulse on the first cycle of each grant
//   res_sel_o    : ID of the current / last winner
//   res_done_i   : resource completion pulse (honoured in BUSY after start)
//   busy_o       : high while a grant is outstanding
//   timeout_o    : one-cycle pulse when the watchdog revokes a grant
// -----------------------------------------------------------------------------
module rr_resource_sched #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               res_start_o,
  output logic [ID_W-1:0]    res_sel_o,
  input  logic               res_done_i,
  output logic               busy_o,
  output logic               timeout_o
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_start;
  logic [ID_W-1:0]    r_sel;
  logic               r_timeout;
  logic [ID_W-1:0]    r_last_id;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic [NUM_REQ-1:0] w_win_oh;
  int                 w_idx;
  logic               w_done;
  logic               w_expired;

  // Rotating priority search: candidates are visited from last_id+1 onward,
  // modulo NUM_REQ, so the previous winner is checked last. The modulo form
  // keeps non-power-of-two NUM_REQ correct.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_found  = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    w_idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = (int'(r_last_id) + i) % NUM_REQ;
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(w_idx);
      end
    end
    w_win_oh = NUM_REQ'(1) << w_win;
  end

  // Done is only meaningful once the start cycle has passed (counter >= 1).
  assign w_done    = (r_state == S_BUSY) && res_done_i && (r_cnt != '0);
  assign w_expired = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_start   <= 1'b0;
      r_sel     <= '0;
      r_timeout <= 1'b0;
      r_last_id <= ID_W'(NUM_REQ - 1);
      r_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge value of every other register.
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state   <= S_BUSY;
            r_gnt     <= w_win_oh;
            r_sel     <= w_win;
            r_start   <= 1'b1;
            r_last_id <= w_win;
            r_cnt     <= '0;
          end
        end
        S_BUSY: begin
          if (w_done) begin
            // Back-to-back hand-off: re-arbitrate immediately with the
            // current winner as the lowest-priority candidate.
            if (w_found) begin
              r_gnt     <= w_win_oh;
              r_sel     <= w_win;
              r_start   <= 1'b1;
              r_last_id <= w_win;
            end else begin
              r_state <= S_IDLE;
              r_gnt   <= '0;
            end
            r_cnt <= '0;
          end else if (w_expired) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign res_start_o = r_start;
  assign res_sel_o   = r_sel;
  assign busy_o      = (r_state == S_BUSY);
  assign timeout_o   = r_timeout;

endmodule
